pattern_sequencer: RTL and testbench

- Control block for the VGA pattern generator: turns raw push-buttons into pattern selection and horizontal scroll settings.
- Debounces the four buttons and queues press events.
- Commits all changes only at frame boundaries, so a pattern or offset never changes mid-frame.
- Optional auto-cycle mode advances the pattern every AUTO_FRAMES frames; outputs drive the pattern mux and the x coordinate offset adder.

---
 rtl/pattern_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_pattern_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pattern_sequencer
//
// Purpose:
//   Control block for the VGA pattern generator. It turns four raw push-buttons
//   into a pattern index and a horizontal scroll offset. Each button is
//   synchronized, debounced and turned into a single press event. Press events
//   wait in pending flags until the next frame boundary, so the visible
//   pattern and offset never change in the middle of a frame. An optional
//   auto-cycle mode advances the pattern every AUTO_FRAMES frames.
//
// Parameters:
//   NUM_PATTERNS    number of selectable patterns (2..8); pattern_sel wraps
//   DEBOUNCE_CYCLES stable synchronized samples needed to accept a level change
//   AUTO_FRAMES     frames shown per pattern in auto mode (1..4095)
//   X_STEP          x_offset change per left/right press
//
// Ports:
//   clk         in   pixel/system clock
//   reset       in   asynchronous active-high reset
//   up          in   raw button: next pattern
//   down        in   raw button: previous pattern
//   left        in   raw button: x_offset -= X_STEP
//   right       in   raw button: x_offset += X_STEP
//   auto_en     in   synchronous level: enable auto-cycle
//   frame_start in   one-cycle pulse at the first line of vertical blank
//   pattern_sel out  registered pattern index for the graphics mux
//   x_offset    out  registered horizontal offset (added to coord_x downstream)
//   changed     out  one-cycle pulse after a commit that altered an output
// -----------------------------------------------------------------------------
module pattern_sequencer #(
  parameter int NUM_PATTERNS    = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int AUTO_FRAMES     = 120,
  parameter int X_STEP          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       auto_en,
  input  logic       frame_start,
  output logic [2:0] pattern_sel,
  output logic [9:0] x_offset,
  output logic       changed
);

  // Button index map used throughout the block.
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;

  // Debounce counter width; clamped so a tiny DEBOUNCE_CYCLES still builds.
  localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);

  // The sample that moves a button into a CHK state is the first stable
  // sample, so the CHK state finishes when the counter is about to reach
  // DEBOUNCE_CYCLES-1, i.e. when it currently holds DEBOUNCE_CYCLES-2.
  localparam int CNT_LAST_INT = (DEBOUNCE_CYCLES >= 2) ? (DEBOUNCE_CYCLES - 2) : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_INT);

  localparam logic [2:0]  PAT_MAX    = 3'(NUM_PATTERNS - 1);
  localparam logic [11:0] FRAME_LAST = 12'(AUTO_FRAMES - 1);
  localparam logic [9:0]  STEP       = 10'(X_STEP);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_CHK,
    PRESSED,
    RELEASE_CHK
  } deb_state_t;

  logic [3:0]  raw_buttons;
  logic [3:0]  sync_q1;
  logic [3:0]  sync_q2;
  logic [3:0]  accept;
  logic [3:0]  pending;

  logic [11:0] frame_cnt;
  logic [11:0] frame_next;
  logic [2:0]  pat_next;
  logic [9:0]  off_next;
  logic [2:0]  pat_inc;
  logic [2:0]  pat_dec;
  logic        manual_event;
  logic        offset_event;

  assign raw_buttons = {right, left, down, up};

  // Two-flop synchronizer for all four asynchronous buttons.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= raw_buttons;
      sync_q2 <= sync_q1;
    end
  end

  // One debounce FSM per button. A press is only accepted once the
  // synchronized level has been stable for DEBOUNCE_CYCLES samples, and the
  // release must be equally stable before a new press can be recognised, so
  // a held button produces exactly one event.
  genvar g;
  for (g = 0; g < 4; g++) begin : g_debounce
    deb_state_t       state;
    deb_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             hit;
    logic             sync_bit;

    assign sync_bit  = sync_q2[g];
    assign accept[g] = hit;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state <= RELEASED;
        cnt   <= '0;
      end else begin
        state <= state_next;
        cnt   <= cnt_next;
      end
    end

    always_comb begin
      state_next = state;
      cnt_next   = cnt;
      hit        = 1'b0;
      unique case (state)
        RELEASED: begin
          if (sync_bit) begin
            state_next = PRESS_CHK;
            cnt_next   = '0;
          end
        end
        PRESS_CHK: begin
          if (!sync_bit) begin
            state_next = RELEASED;
            cnt_next   = '0;
          end else if (cnt == CNT_LAST) begin
            state_next = PRESSED;
            cnt_next   = cnt + 1'b1;
            hit        = 1'b1;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!sync_bit) begin
            state_next = RELEASE_CHK;
            cnt_next   = '0;
          end
        end
        RELEASE_CHK: begin
          if (sync_bit) begin
            state_next = PRESSED;
            cnt_next   = '0;
          end else if (cnt == CNT_LAST) begin
            state_next = RELEASED;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        default: begin
          state_next = RELEASED;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Pending flags: a commit clears what it consumed, but an event accepted on
  // the commit edge itself survives into the next frame. Repeated presses
  // within a frame simply re-set an already set flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= accept | (pending & {4{~frame_start}});
    end
  end

  // Wrapping increment/decrement of the pattern index.
  assign pat_inc = (pattern_sel >= PAT_MAX) ? 3'd0 : (pattern_sel + 3'd1);
  assign pat_dec = (pattern_sel == 3'd0) ? PAT_MAX : (pattern_sel - 3'd1);

  assign manual_event = pending[BTN_UP] ^ pending[BTN_DOWN];
  assign offset_event = pending[BTN_RIGHT] ^ pending[BTN_LEFT];

  // Next committed values. Opposing presses cancel out; a manual pattern
  // change takes priority over auto-cycle and restarts the frame count.
  always_comb begin
    pat_next   = pattern_sel;
    off_next   = x_offset;
    frame_next = frame_cnt;

    if (manual_event) begin
      frame_next = '0;
      pat_next   = pending[BTN_UP] ? pat_inc : pat_dec;
    end else if (auto_en) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_next = '0;
        pat_next   = pat_inc;
      end else begin
        frame_next = frame_cnt + 12'd1;
      end
    end else begin
      frame_next = '0;
    end

    if (offset_event) begin
      off_next = pending[BTN_RIGHT] ? (x_offset + STEP) : (x_offset - STEP);
    end
  end

  // Output registers only move on a frame_start edge; changed is a single
  // cycle pulse following a commit that actually altered something.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern_sel <= '0;
      x_offset    <= '0;
      frame_cnt   <= '0;
      changed     <= 1'b0;
    end else if (frame_start) begin
      pattern_sel <= pat_next;
      x_offset    <= off_next;
      frame_cnt   <= frame_next;
      changed     <= (pat_next != pattern_sel) || (off_next != x_offset);
    end else begin
      changed     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_pattern_sequencer
//
// Self-checking bench for pattern_sequencer with small parameters. Expected
// output values come from a behavioural model kept in the bench; every time
// stimulus is applied the expected outputs are pushed into a scoreboard queue
// and popped when the DUT outputs are sampled (#1 after the clock edge).
// -----------------------------------------------------------------------------
module tb_pattern_sequencer;

  localparam int NUM_PATTERNS    = 4;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int AUTO_FRAMES     = 3;
  localparam int X_STEP          = 8;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] buttons;
  logic       auto_en;
  logic       frame_start;
  logic [2:0] pattern_sel;
  logic [9:0] x_offset;
  logic       changed;

  typedef struct {
    int    pat;
    int    off;
    int    chg;
    string tag;
  } exp_t;

  exp_t sb_q[$];

  int compared   = 0;
  int mismatched = 0;

  // Reference model state.
  int   m_pat;
  int   m_off;
  int   m_frame;
  logic [3:0] m_pend;

  pattern_sequencer #(
    .NUM_PATTERNS   (NUM_PATTERNS),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .AUTO_FRAMES    (AUTO_FRAMES),
    .X_STEP         (X_STEP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .up         (buttons[BTN_UP]),
    .down       (buttons[BTN_DOWN]),
    .left       (buttons[BTN_LEFT]),
    .right      (buttons[BTN_RIGHT]),
    .auto_en    (auto_en),
    .frame_start(frame_start),
    .pattern_sel(pattern_sel),
    .x_offset   (x_offset),
    .changed    (changed)
  );

  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    if (observed != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Queue the model's current outputs with no change pulse.
  task automatic expectIdle(input string tag);
    exp_t e;
    e.pat = m_pat;
    e.off = m_off;
    e.chg = 0;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  // Pop one expectation and compare it with the live DUT outputs.
  task automatic popCheck();
    exp_t e;
    checkOutput("scoreboard_has_entry", (sb_q.size() > 0) ? 1 : 0, 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checkOutput({e.tag, "_pattern_sel"}, int'(pattern_sel), e.pat);
      checkOutput({e.tag, "_x_offset"}, int'(x_offset), e.off);
      checkOutput({e.tag, "_changed"}, int'(changed), e.chg);
    end
  endtask

  // Press one button for 'hold' cycles, release it long enough for the
  // debouncer to settle, then verify the outputs did not move.
  task automatic applyStimulus(input int btn, input int hold);
    @(negedge clk);
    buttons[btn] = 1'b1;
    repeat (hold) @(negedge clk);
    buttons[btn] = 1'b0;
    repeat (12) @(negedge clk);
    if (hold >= DEBOUNCE_CYCLES) m_pend[btn] = 1'b1;
    expectIdle($sformatf("idle_after_btn%0d", btn));
    popCheck();
  endtask

  // Model one commit, queue the commit-cycle and following-cycle
  // expectations, pulse frame_start and check both cycles.
  task automatic commitFrame(input string tag);
    int   old_pat;
    int   old_off;
    exp_t e;
    old_pat = m_pat;
    old_off = m_off;
    if (m_pend[BTN_UP] != m_pend[BTN_DOWN]) begin
      m_pat   = m_pend[BTN_UP] ? (m_pat + 1) % NUM_PATTERNS
                               : (m_pat + NUM_PATTERNS - 1) % NUM_PATTERNS;
      m_frame = 0;
    end else if (auto_en) begin
      if (m_frame == AUTO_FRAMES - 1) begin
        m_frame = 0;
        m_pat   = (m_pat + 1) % NUM_PATTERNS;
      end else begin
        m_frame = m_frame + 1;
      end
    end else begin
      m_frame = 0;
    end
    if (m_pend[BTN_RIGHT] != m_pend[BTN_LEFT]) begin
      m_off = m_pend[BTN_RIGHT] ? (m_off + X_STEP) % 1024
                                : (m_off + 1024 - X_STEP) % 1024;
    end
    m_pend = '0;

    e.pat = m_pat;
    e.off = m_off;
    e.chg = ((m_pat != old_pat) || (m_off != old_off)) ? 1 : 0;
    e.tag = tag;
    sb_q.push_back(e);
    expectIdle({tag, "_next"});

    @(negedge clk);
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    popCheck();
    @(posedge clk);
    #1;
    popCheck();
  endtask

  // Hard stop in case something wedges the stimulus.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    buttons     = '0;
    auto_en     = 1'b0;
    frame_start = 1'b0;
    m_pat       = 0;
    m_off       = 0;
    m_frame     = 0;
    m_pend      = '0;

    repeat (3) @(negedge clk);
    expectIdle("in_reset");
    popCheck();
    reset = 1'b0;
    @(negedge clk);
    expectIdle("after_reset");
    popCheck();

    // Clean press, then a glitch that must be rejected.
    applyStimulus(BTN_UP, 20);
    commitFrame("up_press");
    applyStimulus(BTN_UP, 3);
    commitFrame("up_glitch");

    // Down wraps below zero, left wraps below zero.
    applyStimulus(BTN_DOWN, 20);
    commitFrame("down_to_zero");
    applyStimulus(BTN_DOWN, 20);
    commitFrame("down_wrap");
    applyStimulus(BTN_LEFT, 20);
    commitFrame("left_wrap");

    // Opposing pattern presses cancel; repeated right presses collapse.
    applyStimulus(BTN_UP, 20);
    applyStimulus(BTN_DOWN, 20);
    for (int i = 0; i < 3; i++) applyStimulus(BTN_RIGHT, 20);
    commitFrame("cancel_collapse");

    // Auto-cycle over six frames.
    @(negedge clk);
    auto_en = 1'b1;
    for (int i = 0; i < 6; i++) commitFrame($sformatf("auto_frame%0d", i + 1));

    // Manual press during the second frame restarts the frame count.
    commitFrame("auto_frame_a");
    applyStimulus(BTN_UP, 20);
    commitFrame("auto_manual");
    for (int i = 0; i < 3; i++) commitFrame($sformatf("auto_restart%0d", i + 1));

    @(negedge clk);
    auto_en = 1'b0;
    commitFrame("auto_off");

    // Reset with an event pending and another button mid-debounce.
    applyStimulus(BTN_UP, 20);
    @(negedge clk);
    buttons[BTN_LEFT] = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    m_pat   = 0;
    m_off   = 0;
    m_frame = 0;
    m_pend  = '0;
    expectIdle("async_reset");
    popCheck();
    buttons = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    commitFrame("post_reset_commit");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
